// File: rtl/result_stream_out.sv
// Read-side sequencer for the sorted-result frame buffer: sweeps all NPIX RAM
// addresses after a start pulse and streams the words out through a small FIFO.
module result_stream_out #(
    parameter int NPIX   = 16384,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              busy_rst,
    input  logic              start,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [ADDR_W-1:0] out_index,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   NPIX_P   = (ADDR_W+1)'(NPIX);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX - 1);
    localparam logic [CNT_W:0]    DEPTH_P  = (CNT_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } beat_t;

    state_t            state;
    logic [ADDR_W:0]   rd_ptr;
    logic [1:0]        vld_pipe;   // [0]: read issued this cycle, [1]: rdata valid
    logic [ADDR_W-1:0] wr_idx;
    beat_t             fifo [DEPTH];
    logic [PTR_W-1:0]  wp, rp;
    logic [CNT_W-1:0]  count;

    logic            start_acc, issue, push, pop;
    logic [CNT_W:0]  outstanding;
    beat_t           head;

    assign start_acc   = start && (state == IDLE || state == DONE);
    assign outstanding = (CNT_W+1)'(count) + (CNT_W+1)'(vld_pipe[0]) + (CNT_W+1)'(vld_pipe[1]);
    // Every word in flight already owns a FIFO slot, so the FIFO cannot overflow.
    assign issue = start_acc ||
                   (state == RUN && rd_ptr < NPIX_P && outstanding < DEPTH_P);
    assign push  = vld_pipe[1];
    assign pop   = out_valid && out_ready;

    assign mem_ren   = vld_pipe[0];
    assign out_valid = (count != '0);
    assign head      = fifo[rp];
    assign out_data  = out_valid ? head.data : '0;
    assign out_index = out_valid ? head.idx  : '0;
    assign out_last  = out_valid && (head.idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (push) fifo[wp] <= '{idx: wr_idx, data: mem_rdata};
    end

    always_ff @(posedge clk or negedge busy_rst) begin
        if (!busy_rst) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            vld_pipe  <= '0;
            mem_raddr <= '0;
            wr_idx    <= '0;
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0], issue};

            if (issue) mem_raddr <= start_acc ? '0 : rd_ptr[ADDR_W-1:0];
            if (start_acc)  rd_ptr <= (ADDR_W+1)'(1);
            else if (issue) rd_ptr <= rd_ptr + 1'b1;

            if (start_acc)  wr_idx <= '0;
            else if (push)  wr_idx <= wr_idx + 1'b1;

            if (push) wp <= (wp == PTR_MAX) ? '0 : wp + 1'b1;
            if (pop)  rp <= (rp == PTR_MAX) ? '0 : rp + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);

            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
                RUN: if (rd_ptr == NPIX_P) state <= DRAIN;
                DRAIN: if (pop && head.idx == LAST_IDX) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: if (start) begin
                    state <= RUN;
                    busy  <= 1'b1;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_stream_out.sv
// Directed bench for result_stream_out: reset, full frame, restart from DONE with
// backpressure, mid-frame reset and ready held low from start.
module tb_result_stream_out;
    localparam int NPIX   = 16384;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              busy_rst = 1'b0;
    logic              start = 1'b0;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [ADDR_W-1:0] out_index;
    logic              busy;
    logic              done;

    int n_asrt = 0;
    int n_fail = 0;
    int cyc, exp_idx, issued, accepted, k;
    logic              stall_hold;
    logic [DATA_W-1:0] held_data;
    logic [ADDR_W-1:0] held_idx;

    result_stream_out #(.NPIX(NPIX), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .busy_rst(busy_rst), .start(start),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_index(out_index), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // RAM holds RAM[i] = i[7:0], one-cycle synchronous read
    always_ff @(posedge clk) begin
        if (mem_ren) mem_rdata <= mem_raddr[DATA_W-1:0];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {mem_ren, mem_raddr, out_valid, out_data, out_last, out_index, busy, done}, 64'd0);
    endtask

    task automatic clear_model();
        exp_idx = 0; issued = 0; accepted = 0; stall_hold = 1'b0;
    endtask

    // One cycle: drive inputs, check the current cycle's outputs, advance to the next cycle.
    task automatic cyc_step(input logic rdy, input logic st);
        out_ready = rdy;
        start     = st;
        if (mem_ren) issued++;
        chk("outstanding_le_depth", 64'(issued - accepted <= DEPTH), 64'd1);
        if (stall_hold) begin
            chk("stall_data_stable",  64'(out_data),  64'(held_data));
            chk("stall_index_stable", 64'(out_index), 64'(held_idx));
        end
        if (out_valid && rdy) begin
            chk("beat_data",  64'(out_data),  64'(exp_idx % 256));
            chk("beat_index", 64'(out_index), 64'(exp_idx));
            chk("beat_last",  64'(out_last),  64'(exp_idx == NPIX - 1));
            exp_idx++;
            accepted++;
        end
        stall_hold = out_valid && !rdy;
        held_data  = out_data;
        held_idx   = out_index;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        clear_model();
        cyc = 0;

        // Reset held with random inputs
        for (int i = 0; i < 8; i++) begin
            start     = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk_all_zero("reset_outputs");
        end
        start = 1'b0;
        busy_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc_step(1'b1, 1'b0);
            chk("idle_no_ren", 64'({mem_ren, busy, done}), 64'd0);
        end

        // Full frame, ready=1, stray start at beat 100
        clear_model();
        cyc = 0;
        cyc_step(1'b1, 1'b1);
        chk("c1_ren",  64'(mem_ren),   64'd1);
        chk("c1_addr", 64'(mem_raddr), 64'd0);
        chk("c1_busy", 64'({busy, done}), 64'b10);
        while (cyc <= NPIX + 2) begin
            if (cyc == 2) chk("c2_no_valid", 64'(out_valid), 64'd0);
            if (cyc >= 3) chk("no_gap_valid", 64'(out_valid), 64'd1);
            if (cyc == 3) chk("c3_first", 64'({out_index, out_data}), 64'd0);
            if (cyc == NPIX + 2) begin
                chk("last_beat",  64'({out_last, out_index, out_data}), {41'd0, 1'b1, 14'h3FFF, 8'hFF});
                chk("done_not_early", 64'(done), 64'd0);
            end
            cyc_step(1'b1, exp_idx == 100);
        end
        chk("done_at_npix3", 64'({done, busy, out_valid}), 64'b100);
        chk("frame_a_beats", 64'(exp_idx), 64'(NPIX));

        // Start in DONE restarts; then 1-of-3 backpressure
        clear_model();
        cyc_step(1'b1, 1'b1);
        chk("restart_done_drops", 64'({done, busy}), 64'b01);
        chk("restart_ren_addr",   64'({mem_ren, mem_raddr}), {49'd0, 1'b1, 14'd0});
        k = 0;
        while (exp_idx < 300 && k < 3000) begin
            cyc_step(k % 3 == 0, 1'b0);
            k++;
        end
        chk("bp_progress", 64'(exp_idx), 64'd300);
        k = 0;
        while (exp_idx < 5000 && k < 20000) begin
            cyc_step(1'b1, 1'b0);
            k++;
        end
        chk("reach_5000", 64'(exp_idx), 64'd5000);

        // Asynchronous reset mid-frame
        busy_rst = 1'b0;
        #1;
        chk_all_zero("async_reset_mid");
        @(posedge clk);
        #1;
        chk_all_zero("reset_hold");
        busy_rst = 1'b1;
        clear_model();
        for (int i = 0; i < 3; i++) cyc_step(1'b1, 1'b0);
        chk("post_reset_quiet", 64'({mem_ren, out_valid, busy, done}), 64'd0);

        // Ready low from start, then a clean frame from index 0
        cyc_step(1'b0, 1'b1);
        for (int i = 0; i < 50; i++) cyc_step(1'b0, 1'b0);
        chk("ren_pulses_ready_low", 64'(issued), 64'd4);
        chk("no_accept_ready_low",  64'(accepted), 64'd0);
        chk("head_index0", 64'({out_valid, out_index, out_data}), {41'd0, 1'b1, 22'd0});
        k = 0;
        while (!done && k < NPIX + 100) begin
            cyc_step(1'b1, 1'b0);
            k++;
        end
        chk("frame_c_beats", 64'(exp_idx), 64'(NPIX));
        chk("frame_c_done",  64'({done, busy}), 64'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
